port_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter between the per-port receive queues (RMII and virtual UDP ports) and the single shared 9-bit core data bus. It grants one port at a time and holds the grant for a whole frame. It forwards that frame's bytes with port tag and frame markers, enforces a maximum frame length, and inserts a fixed idle gap between frames. It sits between the port receive outputs and the core data orchestrator's frame input.

---
 rtl/port_frame_arbiter.sv | 177 +++++++++++++++++
 tb/tb_port_frame_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_frame_arbiter.sv
// Frame-granular round-robin arbiter from per-port receive queues onto one 9-bit core bus.
// Latency: grant one cycle after a request is seen idle; forwarded byte one cycle after its pop.
// Backpressure: core_ready gates pops while forwarding; drain after truncation ignores core_ready.
module port_frame_arbiter #(
  parameter int NUMBER_OF_PORTS       = 3,
  parameter int MAX_FRAME_BYTES       = 1522,
  parameter int INTERFRAME_GAP_CYCLES = 2,
  localparam int PW = $clog2(NUMBER_OF_PORTS),
  localparam int CW = $clog2(MAX_FRAME_BYTES + 1),
  localparam int GW = $clog2(INTERFRAME_GAP_CYCLES + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_PORTS-1:0]   port_receive_data_valid,
  input  logic [NUMBER_OF_PORTS*9-1:0] port_receive_data,
  input  logic                         core_ready,
  output logic [NUMBER_OF_PORTS-1:0]   port_receive_data_ready,
  output logic [8:0]                   core_data,
  output logic                         core_data_valid,
  output logic [PW-1:0]                core_port,
  output logic                         core_frame_start,
  output logic                         frame_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FORWARD,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] core_port_q, core_port_d;
  logic [8:0]    core_data_q, core_data_d;
  logic          core_data_valid_q, core_data_valid_d;
  logic          core_frame_start_q, core_frame_start_d;
  logic          frame_timeout_q, frame_timeout_d;

  logic [8:0]    port_byte [NUMBER_OF_PORTS];
  logic [8:0]    cur_byte;
  logic          xfer;
  logic [CW-1:0] cnt_inc;
  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] scan_p;
  int            scan_idx;

  // Unpack the flat per-port byte bus and pick out the granted port's byte.
  always_comb begin
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      port_byte[i] = port_receive_data[i*9 +: 9];
    end
    cur_byte = port_byte[core_port_q];
  end

  // Pop strobe to the granted port only: follows core_ready while forwarding, forced during drain.
  always_comb begin
    port_receive_data_ready = '0;
    if (state_q == ST_FORWARD) begin
      port_receive_data_ready[core_port_q] = core_ready;
    end else if (state_q == ST_DRAIN) begin
      port_receive_data_ready[core_port_q] = 1'b1;
    end
  end

  // Round-robin scan starting at the pointer; first requesting port wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    scan_p    = '0;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      scan_idx = (int'(ptr_q) + i) % NUMBER_OF_PORTS;
      scan_p   = PW'(scan_idx);
      if (!sel_found && port_receive_data_valid[scan_p]) begin
        sel_found = 1'b1;
        sel_idx   = scan_p;
      end
    end
  end

  assign xfer    = port_receive_data_valid[core_port_q] & port_receive_data_ready[core_port_q];
  // Byte counter saturates at the maximum so it can never wrap back into a legal length.
  assign cnt_inc = (cnt_q == CW'(MAX_FRAME_BYTES)) ? cnt_q : cnt_q + 1'b1;

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    cnt_d              = cnt_q;
    gap_d              = gap_q;
    core_port_d        = core_port_q;
    core_data_d        = core_data_q;
    core_data_valid_d  = 1'b0;
    core_frame_start_d = 1'b0;
    frame_timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          core_port_d = sel_idx;
          cnt_d       = '0;
          state_d     = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        if (xfer) begin
          cnt_d              = cnt_inc;
          core_data_d        = cur_byte;
          core_data_valid_d  = 1'b1;
          core_frame_start_d = (cnt_q == '0);
          if (cur_byte[8]) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else if (cnt_inc == CW'(MAX_FRAME_BYTES)) begin
            // Truncate: close the frame downstream, then discard the rest of it.
            core_data_d[8]  = 1'b1;
            frame_timeout_d = 1'b1;
            state_d         = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (cur_byte[8]) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(INTERFRAME_GAP_CYCLES - 1)) begin
          ptr_d   = (core_port_q == PW'(NUMBER_OF_PORTS - 1)) ? '0 : core_port_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      ptr_q              <= '0;
      cnt_q              <= '0;
      gap_q              <= '0;
      core_port_q        <= '0;
      core_data_q        <= '0;
      core_data_valid_q  <= 1'b0;
      core_frame_start_q <= 1'b0;
      frame_timeout_q    <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      cnt_q              <= cnt_d;
      gap_q              <= gap_d;
      core_port_q        <= core_port_d;
      core_data_q        <= core_data_d;
      core_data_valid_q  <= core_data_valid_d;
      core_frame_start_q <= core_frame_start_d;
      frame_timeout_q    <= frame_timeout_d;
    end
  end

  assign core_data        = core_data_q;
  assign core_data_valid  = core_data_valid_q;
  assign core_port        = core_port_q;
  assign core_frame_start = core_frame_start_q;
  assign frame_timeout    = frame_timeout_q;

endmodule

// File: tb/tb_port_frame_arbiter.sv
// Bench for port_frame_arbiter: bench-owned port queues feed the DUT, a frame-level
// round-robin model predicts the forwarded byte stream, and directed steps probe
// grant latency, inter-frame gap, backpressure, truncation and mid-frame reset.
module tb_port_frame_arbiter;
  localparam int NP  = 3;
  localparam int MAX = 8;
  localparam int G   = 2;
  localparam int PW  = $clog2(NP);

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_receive_data_valid;
  logic [NP*9-1:0]   port_receive_data;
  logic              core_ready;
  logic [NP-1:0]     port_receive_data_ready;
  logic [8:0]        core_data;
  logic              core_data_valid;
  logic [PW-1:0]     core_port;
  logic              core_frame_start;
  logic              frame_timeout;

  port_frame_arbiter #(
    .NUMBER_OF_PORTS(NP),
    .MAX_FRAME_BYTES(MAX),
    .INTERFRAME_GAP_CYCLES(G)
  ) dut (
    .clock(clock),
    .reset(reset),
    .port_receive_data_valid(port_receive_data_valid),
    .port_receive_data(port_receive_data),
    .core_ready(core_ready),
    .port_receive_data_ready(port_receive_data_ready),
    .core_data(core_data),
    .core_data_valid(core_data_valid),
    .core_port(core_port),
    .core_frame_start(core_frame_start),
    .frame_timeout(frame_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         port;
    logic [8:0] d;
    logic       st;
    logic       to;
  } exp_t;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [8:0] src [NP][$];
  logic [8:0] mq  [NP][$];
  exp_t       exp_q [$];
  logic       mid [NP];
  int         fstall [NP];
  int         m_ptr = 0;
  int         cr_mode = 0;
  logic       rstall_en = 1'b0;
  logic       gap_chk_en = 1'b0;
  logic       have_last = 1'b0;
  int         last_cyc = 0;
  int         mcyc = 0;
  int         n_to = 0;
  logic [NP-1:0] prev_rdy = '0;
  logic [NP-1:0] ready_s;
  logic          cr_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input int p, input logic [8:0] b);
    src[p].push_back(b);
    mq[p].push_back(b);
  endtask

  task automatic load_frame(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      push_byte(p, {(i == len - 1), 8'($urandom)});
    end
  endtask

  // Reference model: whole frames in round-robin order from the scan pointer;
  // bytes past the length limit are dropped and the limit byte is marked last.
  task automatic run_model();
    logic       any;
    int         p;
    int         n;
    logic       trunc;
    logic [8:0] b;
    exp_t       e;
    forever begin
      any = 1'b0;
      p = 0;
      for (int k = 0; k < NP; k++) begin
        if (!any && mq[(m_ptr + k) % NP].size() > 0) begin
          any = 1'b1;
          p = (m_ptr + k) % NP;
        end
      end
      if (!any) break;
      n = 0;
      trunc = 1'b0;
      do begin
        b = mq[p].pop_front();
        if (!trunc) begin
          n++;
          e.port = p;
          e.st = (n == 1);
          e.d = b;
          e.to = 1'b0;
          if (!b[8] && n == MAX) begin
            e.d[8] = 1'b1;
            e.to = 1'b1;
            trunc = 1'b1;
          end
          exp_q.push_back(e);
        end
      end while (!b[8]);
      m_ptr = (p + 1) % NP;
    end
  endtask

  task automatic drive();
    logic stall;
    for (int p = 0; p < NP; p++) begin
      stall = (fstall[p] > 0) || (rstall_en && mid[p] && $urandom_range(0, 3) == 0);
      port_receive_data_valid[p] = (src[p].size() > 0) && !stall;
      port_receive_data[p*9 +: 9] = (src[p].size() > 0) ? src[p][0] : 9'h000;
    end
  endtask

  task automatic step();
    logic [NP-1:0] fire;
    logic [8:0]    b;
    @(negedge clock);
    ready_s = port_receive_data_ready;
    cr_s = core_ready;
    fire = ready_s & port_receive_data_valid;
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) begin
        b = src[p].pop_front();
        mid[p] = !b[8];
      end
      if (fstall[p] > 0) fstall[p]--;
    end
    case (cr_mode)
      0: core_ready = 1'b1;
      1: core_ready = ~core_ready;
      default: core_ready = ($urandom_range(0, 3) != 0);
    endcase
    drive();
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src[0].size() != 0 || src[1].size() != 0 ||
            src[2].size() != 0) && k < 3000) begin
      step();
      k++;
    end
    chk("drain_within_budget", {31'd0, (k < 3000)}, 32'd1);
    repeat (G + 3) step();
  endtask

  // Output monitor: every forwarded byte must match the model's next byte.
  always @(negedge clock) begin
    logic [NP-1:0] rdy;
    logic [NP-1:0] fire;
    exp_t e;
    if (!reset) begin
      mcyc++;
      rdy = port_receive_data_ready;
      fire = rdy & port_receive_data_valid;
      chk("ready_onehot0", {31'd0, $onehot0(rdy)}, 32'd1);
      if (core_data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'd0, core_data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("core_data", {23'd0, core_data}, {23'd0, e.d});
          chk("core_port", {30'd0, core_port}, e.port);
          chk("core_frame_start", {31'd0, core_frame_start}, {31'd0, e.st});
          chk("frame_timeout", {31'd0, frame_timeout}, {31'd0, e.to});
        end
      end else begin
        chk("idle_frame_timeout", {31'd0, frame_timeout}, 32'd0);
      end
      if (frame_timeout) n_to++;
      if (gap_chk_en && have_last && prev_rdy == '0 && rdy != '0) begin
        chk("gap_to_next_ready", mcyc - last_cyc, G + 2);
        have_last = 1'b0;
      end
      for (int p = 0; p < NP; p++) begin
        if (fire[p] && port_receive_data[p*9 + 8]) begin
          last_cyc = mcyc;
          have_last = 1'b1;
        end
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    core_ready = 1'b1;
    port_receive_data_valid = '0;
    port_receive_data = '0;
    for (int p = 0; p < NP; p++) begin
      mid[p] = 1'b0;
      fstall[p] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", {29'd0, port_receive_data_ready}, 32'd0);
    chk("rst_core_data", {23'd0, core_data}, 32'd0);
    chk("rst_core_valid", {31'd0, core_data_valid}, 32'd0);
    chk("rst_core_port", {30'd0, core_port}, 32'd0);
    chk("rst_frame_start", {31'd0, core_frame_start}, 32'd0);
    chk("rst_frame_timeout", {31'd0, frame_timeout}, 32'd0);

    // Single 4-byte frame on port 1.
    push_byte(1, 9'h011);
    push_byte(1, 9'h022);
    push_byte(1, 9'h033);
    push_byte(1, 9'h144);
    run_model();
    drive();
    step();
    chk("t1_ready_arb_cycle", {29'd0, ready_s}, 32'd0);
    repeat (4) begin
      step();
      chk("t1_ready_forward", {29'd0, ready_s}, 32'b010);
    end
    step();
    chk("t1_ready_after_last", {29'd0, ready_s}, 32'd0);
    wait_drain();

    // All ports request continuously with 2-byte frames; check the gap.
    have_last = 1'b0;
    gap_chk_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) load_frame(p, 2);
    end
    run_model();
    drive();
    wait_drain();
    gap_chk_en = 1'b0;

    // core_ready toggling during a port 2 frame.
    cr_mode = 1;
    load_frame(2, 6);
    run_model();
    drive();
    k = 0;
    while (src[2].size() > 0 && k < 50) begin
      step();
      if (!cr_s) chk("t3_no_pop_when_not_ready", {29'd0, ready_s}, 32'd0);
      k++;
    end
    cr_mode = 0;
    core_ready = 1'b1;
    wait_drain();

    // Over-length frame on port 0 with port 1 waiting.
    n_to = 0;
    load_frame(0, 12);
    load_frame(1, 3);
    run_model();
    drive();
    wait_drain();
    chk("t4_timeout_pulses", n_to, 32'd1);

    // Port 0 stalls 5 cycles mid-frame while port 1 requests.
    load_frame(0, 6);
    run_model();
    drive();
    k = 0;
    while (src[0].size() > 4 && k < 20) begin
      step();
      k++;
    end
    load_frame(1, 3);
    run_model();
    fstall[0] = 5;
    drive();
    repeat (5) begin
      step();
      chk("t5_grant_held_on_port0", {29'd0, ready_s}, 32'b001);
    end
    wait_drain();

    // Randomized rounds with random backpressure and mid-frame stalls.
    cr_mode = 2;
    rstall_en = 1'b1;
    repeat (6) begin
      for (int p = 0; p < NP; p++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) load_frame(p, $urandom_range(1, 11));
      end
      run_model();
      drive();
      wait_drain();
    end
    cr_mode = 0;
    rstall_en = 1'b0;
    core_ready = 1'b1;
    drive();
    step();

    // Reset during byte 3 of a 6-byte frame.
    load_frame(1, 6);
    run_model();
    drive();
    k = 0;
    while (src[1].size() > 3 && k < 20) begin
      step();
      k++;
    end
    reset = 1'b1;
    #1;
    chk("t7_rst_ready", {29'd0, port_receive_data_ready}, 32'd0);
    chk("t7_rst_core_data", {23'd0, core_data}, 32'd0);
    chk("t7_rst_core_valid", {31'd0, core_data_valid}, 32'd0);
    chk("t7_rst_core_port", {30'd0, core_port}, 32'd0);
    chk("t7_rst_frame_start", {31'd0, core_frame_start}, 32'd0);
    chk("t7_rst_frame_timeout", {31'd0, frame_timeout}, 32'd0);
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      src[p].delete();
      mq[p].delete();
      mid[p] = 1'b0;
    end
    m_ptr = 0;
    drive();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    load_frame(2, 4);
    run_model();
    drive();
    step();
    chk("t7_ready_arb_cycle", {29'd0, ready_s}, 32'd0);
    step();
    chk("t7_ready_port2", {29'd0, ready_s}, 32'b100);
    chk("t7_core_port", {30'd0, core_port}, 32'd2);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
